kme_clk_en_gen: RTL and testbench
=================================

KME_CLK_EN_GEN -- requirements
Module: kme_clk_en_gen

Interface
- REQ-001: Parameter DIV_W, default 8: width of the divide-ratio field.
- REQ-002: Parameter HOLD_CYCLES, default 16: number of cycles the DUT reset is held after reset release; legal range 1..255.
- REQ-003: Parameter CNT_W, default 32: width of the enabled-cycle counter.
- REQ-004: clk  in  1  free-running 800 MHz emulation master clock (my_clk); sole clock.
- REQ-005: rst  in  1  synchronous, active-high reset.
- REQ-006: run_en  in  1  high = divider runs; low = pause.
- REQ-007: cfg_valid  in  1  new divide ratio offered.
- REQ-008: cfg_div  in  DIV_W  divide ratio; enable period = cfg_div+1 cycles.
- REQ-009: cfg_ready  out  1  ratio update can be accepted.
- REQ-010: dut_rst  out  1  sequenced active-high reset to downstream DUT logic.
- REQ-011: clk_en  out  1  one-cycle clock-enable pulse.
- REQ-012: phase_wrap  out  1  pulses on the same cycle as clk_en when the divider wraps.
- REQ-013: en_cnt  out  CNT_W  count of clk_en pulses issued since reset.

Function
- REQ-014: The FSM shall have exactly three states: HOLD, RUN, PAUSE.
- REQ-015: HOLD shall assert dut_rst, count HOLD_CYCLES cycles, then go to RUN if run_en, otherwise PAUSE; dut_rst shall deassert on the first cycle in RUN or PAUSE.
- REQ-016: RUN shall go to PAUSE on run_en=0; PAUSE shall go to RUN on run_en=1; the transition takes effect on the next cycle.
- REQ-017: In RUN, the phase counter shall increment each cycle and wrap to 0 when it equals the active ratio; clk_en and phase_wrap shall be high on the wrap cycle only.
- REQ-018: Active ratio 0 shall give clk_en high on every RUN cycle.
- REQ-019: In PAUSE, the phase counter shall hold its value and clk_en shall be 0; on resume, counting continues from the held phase.
- REQ-020: The ratio update handshake shall complete on a cycle with cfg_valid && cfg_ready; cfg_div is captured into a pending register.
- REQ-021: cfg_ready shall be 0 in HOLD and while an update is pending, and 1 otherwise.
- REQ-022: In RUN, a pending ratio shall become active on the cycle after the next wrap, with the phase restarting at 0.
- REQ-023: In PAUSE, a pending ratio shall become active on the next cycle and reset the phase to 0.
- REQ-024: If an accept and a wrap occur on the same cycle, the accepted ratio shall be applied at the following wrap, not the current one.
- REQ-025: en_cnt shall increment on every clk_en pulse and wrap modulo 2^CNT_W without a flag.

Reset
- REQ-026: On rst=1, the block shall enter HOLD with: dut_rst=1, clk_en=0, phase_wrap=0, cfg_ready=0, en_cnt=0, phase=0, hold counter=0, active ratio=0, no pending update.
- REQ-027: Assertion of rst mid-operation shall abort any pending update and restart the full HOLD sequence.

Structure
- REQ-028: A shared package kme_clk_pkg shall hold the state enum (HOLD/RUN/PAUSE) and the DIV_W and CNT_W defaults.
- REQ-029: The phase counter with wrap detection shall be a sub-module, kme_phase_ctr; everything else is flat.

Verification
- REQ-030: Release rst with run_en=1 and HOLD_CYCLES=16 -> dut_rst is high for exactly 16 cycles after release, then low; the first clk_en appears 1 cycle later (ratio 0).
- REQ-031: Accept cfg_div=3 in RUN -> after the next wrap, clk_en fires every 4 cycles; en_cnt increments by 1 per pulse.
- REQ-032: Drop run_en at phase 2 of ratio 3 for 10 cycles, then raise it -> no clk_en during the pause; the next clk_en comes 2 cycles after resume.
- REQ-033: Accept cfg_div=1 on the exact wrap cycle of ratio 3 -> one more period of 4 cycles, then a period of 2.
- REQ-034: Assert rst for 1 cycle while an update is pending -> pending update dropped, dut_rst re-held for 16 cycles, active ratio 0.
- REQ-035: Preload en_cnt near 2^CNT_W-1 (force) and issue 2 pulses -> en_cnt reads 0 then 1.

Source files
------------

// File: rtl/kme_clk_pkg.sv
// Shared types and default widths for the emulation clock-enable generator.
package kme_clk_pkg;

    localparam int unsigned DIV_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 32;
    // Hold counter width; covers the full legal HOLD_CYCLES range 1..255.
    localparam int unsigned HOLD_W    = 8;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/kme_phase_ctr.sv
// Phase counter for the clock-enable divider.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   cnt_en    - advance the phase this cycle (divider running)
//   clr       - force the phase back to 0 (new ratio taking effect)
//   ratio     - active divide ratio; the phase wraps after reaching it
//   wrap_c    - combinational: phase equals ratio while counting
module kme_phase_ctr #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             clr,
    input  logic [DIV_W-1:0] ratio,
    output logic             wrap_c
);

    logic [DIV_W-1:0] phase_q;
    logic [DIV_W-1:0] phase_d;

    // Wrap detection and next phase; the phase simply holds when not counting.
    always_comb begin
        wrap_c  = cnt_en && (phase_q == ratio);
        phase_d = phase_q;
        if (clr || wrap_c) begin
            phase_d = '0;
        end else if (cnt_en) begin
            phase_d = phase_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/kme_clk_en_gen.sv
// Clock-enable generator for the emulation master clock: sequences the
// downstream DUT reset, then issues a one-cycle clk_en every (ratio+1)
// cycles while running, with a ready/valid port for changing the ratio.
// Ports:
//   clk, rst   - master clock, synchronous active-high reset
//   run_en     - 1 = divider runs, 0 = pause (phase held)
//   cfg_valid  - new ratio offered on cfg_div
//   cfg_div    - divide ratio; enable period is cfg_div+1 cycles
//   cfg_ready  - a ratio update can be accepted
//   dut_rst    - active-high reset to downstream logic, high during HOLD
//   clk_en     - one-cycle enable pulse
//   phase_wrap - marks the divider wrap, coincident with clk_en
//   en_cnt     - number of clk_en pulses since reset (wraps silently)
module kme_clk_en_gen
    import kme_clk_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             dut_rst,
    output logic             clk_en,
    output logic             phase_wrap,
    output logic [CNT_W-1:0] en_cnt
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_e            state_q,    state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DIV_W-1:0]  active_q,   active_d;
    logic [DIV_W-1:0]  pend_q,     pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0]  en_cnt_q,   en_cnt_d;
    logic              dut_rst_q,  dut_rst_d;
    logic              clk_en_q,   clk_en_d;
    logic              phase_wrap_q, phase_wrap_d;
    logic              cfg_ready_q, cfg_ready_d;

    logic              wrap_c;
    logic              accept_c;
    logic              apply_c;

    kme_phase_ctr #(
        .DIV_W (DIV_W)
    ) u_phase_ctr (
        .clk    (clk),
        .rst    (rst),
        .cnt_en (state_q == RUN),
        .clr    (apply_c),
        .ratio  (active_q),
        .wrap_c (wrap_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        active_d     = active_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        en_cnt_d     = en_cnt_q;

        case (state_q)
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = run_en ? RUN : PAUSE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RUN: begin
                if (!run_en) state_d = PAUSE;
            end
            PAUSE: begin
                if (run_en) state_d = RUN;
            end
            default: state_d = HOLD;
        endcase

        // cfg_ready is low whenever a ratio is pending, so accept and apply
        // never coincide; an accept on a wrap cycle waits for the next wrap.
        accept_c = cfg_valid && cfg_ready_q;
        apply_c  = pend_vld_q && ((state_q == PAUSE) || wrap_c);

        if (accept_c) begin
            pend_d     = cfg_div;
            pend_vld_d = 1'b1;
        end
        if (apply_c) begin
            active_d   = pend_q;
            pend_vld_d = 1'b0;
        end

        en_cnt_d     = en_cnt_q + CNT_W'(wrap_c);
        clk_en_d     = wrap_c;
        phase_wrap_d = wrap_c;
        dut_rst_d    = (state_d == HOLD);
        cfg_ready_d  = (state_d != HOLD) && !pend_vld_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HOLD;
            hold_cnt_q   <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            en_cnt_q     <= '0;
            dut_rst_q    <= 1'b1;
            clk_en_q     <= 1'b0;
            phase_wrap_q <= 1'b0;
            cfg_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            en_cnt_q     <= en_cnt_d;
            dut_rst_q    <= dut_rst_d;
            clk_en_q     <= clk_en_d;
            phase_wrap_q <= phase_wrap_d;
            cfg_ready_q  <= cfg_ready_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign dut_rst    = dut_rst_q;
    assign clk_en     = clk_en_q;
    assign phase_wrap = phase_wrap_q;
    assign en_cnt     = en_cnt_q;

endmodule

// File: tb/tb_kme_clk_en_gen.sv
// Directed bench for kme_clk_en_gen: reset sequencing, ratio changes,
// pause/resume, accept-on-wrap, reset during a pending update, and
// en_cnt rollover.
module tb_kme_clk_en_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_en;
    logic        cfg_valid;
    logic [7:0]  cfg_div;
    logic        cfg_ready;
    logic        dut_rst;
    logic        clk_en;
    logic        phase_wrap;
    logic [31:0] en_cnt;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] exp_cnt  = 0;

    kme_clk_en_gen #(
        .DIV_W       (8),
        .HOLD_CYCLES (16),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_en     (run_en),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .dut_rst    (dut_rst),
        .clk_en     (clk_en),
        .phase_wrap (phase_wrap),
        .en_cnt     (en_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check all outputs at the following falling edge.
    task automatic step(input logic exp_en, input logic exp_rst, input logic exp_rdy,
                        input string tag);
        @(posedge clk);
        @(negedge clk);
        if (exp_en) exp_cnt = exp_cnt + 32'd1;
        chk({31'd0, clk_en},     {31'd0, exp_en},  {tag, ".clk_en"});
        chk({31'd0, phase_wrap}, {31'd0, exp_en},  {tag, ".phase_wrap"});
        chk({31'd0, dut_rst},    {31'd0, exp_rst}, {tag, ".dut_rst"});
        chk({31'd0, cfg_ready},  {31'd0, exp_rdy}, {tag, ".cfg_ready"});
        chk(en_cnt, exp_cnt, {tag, ".en_cnt"});
    endtask

    initial begin
        rst       = 1'b1;
        run_en    = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({31'd0, dut_rst},    32'd1, "rst.dut_rst");
        chk({31'd0, clk_en},     32'd0, "rst.clk_en");
        chk({31'd0, phase_wrap}, 32'd0, "rst.phase_wrap");
        chk({31'd0, cfg_ready},  32'd0, "rst.cfg_ready");
        chk(en_cnt, 32'd0, "rst.en_cnt");

        // Release: dut_rst held 16 cycles, first clk_en one cycle later.
        rst = 1'b0;
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, "hold");
        step(1'b0, 1'b0, 1'b1, "hold_exit");
        step(1'b1, 1'b0, 1'b1, "first_en");
        step(1'b1, 1'b0, 1'b1, "ratio0");

        // Ratio 3 accepted while ratio 0 wraps every cycle.
        cfg_valid = 1'b1;
        cfg_div   = 8'd3;
        step(1'b1, 1'b0, 1'b0, "acc3");
        cfg_valid = 1'b0;
        step(1'b1, 1'b0, 1'b1, "apply3");
        for (int p = 0; p < 2; p++) begin
            step(1'b0, 1'b0, 1'b1, "r3_gap");
            step(1'b0, 1'b0, 1'b1, "r3_gap");
            step(1'b0, 1'b0, 1'b1, "r3_gap");
            step(1'b1, 1'b0, 1'b1, "r3_pulse");
        end

        // Pause at phase 2 for 10 cycles; pulse comes 2 cycles after resume.
        step(1'b0, 1'b0, 1'b1, "pre_pause");
        step(1'b0, 1'b0, 1'b1, "pre_pause");
        run_en = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, "pause");
        run_en = 1'b1;
        step(1'b0, 1'b0, 1'b1, "resume1");
        step(1'b1, 1'b0, 1'b1, "resume2");
        step(1'b0, 1'b0, 1'b1, "post_resume");
        step(1'b0, 1'b0, 1'b1, "post_resume");
        step(1'b0, 1'b0, 1'b1, "post_resume");
        step(1'b1, 1'b0, 1'b1, "post_resume_pulse");

        // Offer ratio 1 on the wrap cycle: one more period of 4, then 2.
        step(1'b0, 1'b0, 1'b1, "w_ph1");
        step(1'b0, 1'b0, 1'b1, "w_ph2");
        step(1'b0, 1'b0, 1'b1, "w_ph3");
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        step(1'b1, 1'b0, 1'b0, "acc1_on_wrap");
        cfg_valid = 1'b0;
        step(1'b0, 1'b0, 1'b0, "old_period");
        step(1'b0, 1'b0, 1'b0, "old_period");
        step(1'b0, 1'b0, 1'b0, "old_period");
        step(1'b1, 1'b0, 1'b1, "apply1");
        step(1'b0, 1'b0, 1'b1, "r1_gap");
        step(1'b1, 1'b0, 1'b1, "r1_pulse");
        step(1'b0, 1'b0, 1'b1, "r1_gap");
        step(1'b1, 1'b0, 1'b1, "r1_pulse");

        // Reset for one cycle with ratio 5 pending: update dropped.
        cfg_valid = 1'b1;
        cfg_div   = 8'd5;
        step(1'b0, 1'b0, 1'b0, "acc5");
        cfg_valid = 1'b0;
        rst       = 1'b1;
        exp_cnt   = 32'd0;
        step(1'b0, 1'b1, 1'b0, "mid_rst");
        rst = 1'b0;
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, "rehold");
        step(1'b0, 1'b0, 1'b1, "rehold_exit");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, "ratio0_after_rst");

        // en_cnt rollover from 2^32-1.
        force dut.en_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.en_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        step(1'b1, 1'b0, 1'b1, "roll0");
        chk(en_cnt, 32'd0, "roll0.abs");
        step(1'b1, 1'b0, 1'b1, "roll1");
        chk(en_cnt, 32'd1, "roll1.abs");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
